// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : RV32I decode/issue stage producing AluOp/A/B/rd/wen for the
//               ALU through a registered valid/ready output slot.
//               Optional macro ALU_ILLEGAL_EN adds a registered 'illegal' flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [N-1:0] pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   AluOp,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [4:0]   rd,
`ifdef ALU_ILLEGAL_EN
    output logic         illegal,
`endif
    output logic         wen
);

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_SLL  = 4'd2;
    localparam logic [3:0] c_ALU_SLT  = 4'd3;
    localparam logic [3:0] c_ALU_SLTU = 4'd4;
    localparam logic [3:0] c_ALU_XOR  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_OR   = 4'd9;
    localparam logic [3:0] c_ALU_AND  = 4'd10;

    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic [N-1:0] w_imm_i;
    logic [N-1:0] w_imm_u;
    logic [N-1:0] w_shamt;
    logic         w_accept;
    logic         w_unused_rs1_idx;

    logic [3:0]   aluop_d, aluop_q;
    logic [N-1:0] a_d, a_q;
    logic [N-1:0] b_d, b_q;
    logic         legal_d;
    logic         wen_d, wen_q;
    logic [4:0]   rd_q;
    logic         illegal_q;
    logic         out_valid_q;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_imm_i  = N'($signed(instr[31:20]));
    assign w_imm_u  = N'($signed({instr[31:12], 12'b0}));
    assign w_shamt  = N'(instr[24:20]);
    // Register index of rs1 is consumed upstream by the register file.
    assign w_unused_rs1_idx = ^instr[19:15];

    function automatic logic [3:0] f3_to_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SLT;
            3'b011:  op = c_ALU_SLTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        aluop_d = c_ALU_ADD;
        a_d     = '0;
        b_d     = '0;
        legal_d = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                a_d     = rs1_data;
                b_d     = rs2_data;
                aluop_d = f3_to_op(w_funct3);
                legal_d = (w_funct7 == c_F7_ZERO) ||
                          ((w_funct7 == c_F7_ALT) &&
                           ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
                if (w_funct7 == c_F7_ALT) begin
                    aluop_d = (w_funct3 == 3'b000) ? c_ALU_SUB : c_ALU_SRA;
                end
            end
            c_OPC_OPIMM: begin
                a_d     = rs1_data;
                b_d     = w_imm_i;
                aluop_d = f3_to_op(w_funct3);
                legal_d = 1'b1;
                if (w_funct3 == 3'b001) begin
                    b_d     = w_shamt;
                    legal_d = (w_funct7 == c_F7_ZERO);
                end else if (w_funct3 == 3'b101) begin
                    b_d     = w_shamt;
                    legal_d = (w_funct7 == c_F7_ZERO) || (w_funct7 == c_F7_ALT);
                    aluop_d = (w_funct7 == c_F7_ALT) ? c_ALU_SRA : c_ALU_SRL;
                end
            end
            c_OPC_LUI: begin
                b_d     = w_imm_u;
                legal_d = 1'b1;
            end
            c_OPC_AUIPC: begin
                a_d     = pc;
                b_d     = w_imm_u;
                legal_d = 1'b1;
            end
            default: begin
                legal_d = 1'b0;
            end
        endcase
        // Illegal encodings are still issued, but as a harmless ADD 0,0 bubble.
        if (!legal_d) begin
            aluop_d = c_ALU_ADD;
            a_d     = '0;
            b_d     = '0;
        end
        wen_d = legal_d && (instr[11:7] != 5'd0);
    end

    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            aluop_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (w_accept) begin
            out_valid_q <= 1'b1;
            aluop_q     <= aluop_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= instr[11:7];
            wen_q       <= wen_d;
            illegal_q   <= !legal_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign AluOp     = aluop_q;
    assign A         = a_q;
    assign B         = b_q;
    assign rd        = rd_q;
    assign wen       = wen_q;
`ifdef ALU_ILLEGAL_EN
    assign illegal   = illegal_q;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = illegal_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Directed and random checks of alu_issue_stage against an
//               instruction-level reference (random assembler + held-op model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, wen;
    logic [31:0] instr, rs1_data, rs2_data, pc, A, B;
    logic [3:0]  AluOp;
    logic [4:0]  rd;
`ifdef ALU_ILLEGAL_EN
    logic        illegal;
`endif

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .AluOp(AluOp), .A(A), .B(B), .rd(rd),
`ifdef ALU_ILLEGAL_EN
        .illegal(illegal),
`endif
        .wen(wen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    // Instruction tables: R-type, I-type arithmetic, I-type shifts.
    int R_F3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int R_F7 [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    int R_OP [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 10};
    int I_F3 [6]  = '{0, 2, 3, 4, 6, 7};
    int I_OP [6]  = '{0, 3, 4, 5, 9, 10};
    int S_F3 [3]  = '{1, 5, 5};
    int S_F7 [3]  = '{0, 0, 32};
    int S_OP [3]  = '{2, 6, 7};

    int   n_pass = 0;
    int   n_total = 0;
    exp_t held = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic exp_t mk(input int op, input logic [31:0] a, input logic [31:0] b,
                                input int rdv, input logic w, input logic il);
        exp_t e;
        e.v = 1'b1; e.op = 4'(op); e.a = a; e.b = b;
        e.rd = 5'(rdv); e.wen = w; e.ill = il;
        return e;
    endfunction

    task automatic chk_out();
        chk("out_valid", 64'(out_valid), 64'(held.v));
        if (held.v) begin
            chk("AluOp", 64'(AluOp), 64'(held.op));
            chk("A", 64'(A), 64'(held.a));
            chk("B", 64'(B), 64'(held.b));
            chk("rd", 64'(rd), 64'(held.rd));
            chk("wen", 64'(wen), 64'(held.wen));
`ifdef ALU_ILLEGAL_EN
            chk("illegal", 64'(illegal), 64'(held.ill));
`endif
        end
    endtask

    // One clock: drive, check in_ready, advance model and DUT, check outputs.
    task automatic cycle(input logic iv, input logic ordy, input logic fl,
                         input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] p, input exp_t e);
        logic exp_rdy;
        in_valid = iv; out_ready = ordy; flush = fl;
        instr = ins; rs1_data = r1; rs2_data = r2; pc = p;
        #1;
        exp_rdy = !held.v || ordy;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (fl)                   held.v = 1'b0;
        else if (iv && exp_rdy)   held = e;
        else if (ordy)            held.v = 1'b0;
        #1;
        chk_out();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7; pc = 32'h0;
        @(posedge clk);
        #1;
        held = '0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_AluOp", 64'(AluOp), 64'd0);
        chk("rst_A", 64'(A), 64'd0);
        chk("rst_B", 64'(B), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_wen", 64'(wen), 64'd0);
`ifdef ALU_ILLEGAL_EN
        chk("rst_illegal", 64'(illegal), 64'd0);
`endif
        rst = 1'b0;
    endtask

    // Random assembler: picks an instruction and states its meaning directly.
    task automatic gen(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] p,
                       output logic [31:0] ins, output exp_t e);
        int k, i, j;
        logic [31:0] rnd;
        logic [4:0]  rdn, s1, s2, sh;
        logic [2:0]  f3;
        logic [6:0]  f7, opc;
        logic [11:0] imm;
        logic [19:0] u;
        rnd = $urandom;
        rdn = rnd[11:7]; s1 = rnd[19:15]; s2 = rnd[24:20];
        e = '0; e.v = 1'b1; e.rd = rdn;
        k = $urandom_range(0, 5);
        case (k)
            0: begin
                i = $urandom_range(0, 9);
                ins = {7'(R_F7[i]), s2, s1, 3'(R_F3[i]), rdn, 7'h33};
                e.op = 4'(R_OP[i]); e.a = r1; e.b = r2;
            end
            1: begin
                i = $urandom_range(0, 5);
                imm = 12'($urandom);
                ins = {imm, s1, 3'(I_F3[i]), rdn, 7'h13};
                e.op = 4'(I_OP[i]); e.a = r1;
                e.b = imm[11] ? 32'(int'({20'b0, imm}) - 4096) : {20'b0, imm};
            end
            2: begin
                i = $urandom_range(0, 2);
                sh = 5'($urandom);
                ins = {7'(S_F7[i]), sh, s1, 3'(S_F3[i]), rdn, 7'h13};
                e.op = 4'(S_OP[i]); e.a = r1; e.b = {27'b0, sh};
            end
            3: begin
                u = 20'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    ins = {u, rdn, 7'h37}; e.a = 32'd0;
                end else begin
                    ins = {u, rdn, 7'h17}; e.a = p;
                end
                e.b = {12'b0, u} * 32'd4096;
            end
            default: begin
                e.ill = 1'b1;
                j = $urandom_range(0, 3);
                case (j)
                    0: begin
                        do opc = 7'($urandom);
                        while (opc == 7'h33 || opc == 7'h13 || opc == 7'h37 || opc == 7'h17);
                        ins = {rnd[31:7], opc};
                    end
                    1: begin
                        do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
                        ins = {f7, rnd[24:12], rdn, 7'h33};
                    end
                    2: begin
                        do f3 = 3'($urandom); while (f3 == 3'd0 || f3 == 3'd5);
                        ins = {7'h20, rnd[24:15], f3, rdn, 7'h33};
                    end
                    default: begin
                        do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
                        f3 = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
                        ins = {f7, rnd[24:15], f3, rdn, 7'h13};
                    end
                endcase
            end
        endcase
        e.wen = !e.ill && (rdn != 5'd0);
    endtask

    initial begin
        exp_t e_add, e_sub, e_addi, e_ori, e_lui, e_ill, e_rnd;
        logic [31:0] ins, r1, r2, p;
        e_add  = mk(0, 32'd5, 32'd7, 3, 1'b1, 1'b0);
        e_sub  = mk(1, 32'd5, 32'd7, 3, 1'b1, 1'b0);
        e_addi = mk(0, 32'd0, 32'hFFFF_FFFF, 5, 1'b1, 1'b0);
        e_ori  = mk(9, 32'h55, 32'h0000_00F0, 6, 1'b1, 1'b0);
        e_lui  = mk(0, 32'd0, 32'h1234_5000, 1, 1'b1, 1'b0);
        e_ill  = mk(0, 32'd0, 32'd0, 0, 1'b0, 1'b1);

        do_reset();

        cycle(1, 1, 0, 32'h002081B3, 32'd5, 32'd7, 32'h100, e_add);
        cycle(1, 1, 0, 32'h402081B3, 32'd5, 32'd7, 32'h100, e_sub);
        cycle(1, 1, 0, 32'hFFF00293, 32'd0, 32'd9, 32'h100, e_addi);
        cycle(1, 1, 0, 32'h0F036313, 32'h55, 32'd9, 32'h100, e_ori);
        cycle(1, 1, 0, 32'h123450B7, 32'h77, 32'd9, 32'h100, e_lui);
        cycle(1, 1, 0, 32'h00001117, 32'h77, 32'd9, 32'h100,
              mk(0, 32'h100, 32'h1000, 2, 1'b1, 1'b0));
        cycle(1, 1, 0, 32'h0000007F, 32'd3, 32'd4, 32'h100, e_ill);
        cycle(1, 1, 0, 32'h00000033, 32'd3, 32'd4, 32'h100, mk(0, 32'd3, 32'd4, 0, 1'b0, 1'b0));

        // Backpressure: ADD held for three cycles, then SUB issues.
        cycle(1, 1, 0, 32'h002081B3, 32'd5, 32'd7, 32'h100, e_add);
        for (int c = 0; c < 3; c++)
            cycle(1, 0, 0, 32'h402081B3, 32'd5, 32'd7, 32'h100, e_sub);
        cycle(1, 1, 0, 32'h402081B3, 32'd5, 32'd7, 32'h100, e_sub);
        // Flush while held beats the offered input.
        cycle(1, 0, 0, 32'hFFF00293, 32'd0, 32'd9, 32'h100, e_addi);
        cycle(1, 0, 1, 32'hFFF00293, 32'd0, 32'd9, 32'h100, e_addi);
        cycle(1, 0, 0, 32'h0F036313, 32'h55, 32'd9, 32'h100, e_ori);
        cycle(1, 0, 0, 32'h123450B7, 32'h77, 32'd9, 32'h100, e_lui);
        do_reset();
        // Drain without a new input.
        cycle(1, 1, 0, 32'h123450B7, 32'h77, 32'd9, 32'h100, e_lui);
        cycle(0, 1, 0, 32'h002081B3, 32'd5, 32'd7, 32'h100, e_add);

        for (int t = 0; t < 400; t++) begin
            r1 = $urandom; r2 = $urandom; p = $urandom;
            gen(r1, r2, p, ins, e_rnd);
            cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0), ins, r1, r2, p, e_rnd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage driving the ALU: the producer end of the ALU's AluOp/A/B interface.
- Accepts one RV32I integer instruction plus register-file read data per handshake.
- Decodes the instruction into the 4-bit AluOp code, the A and B operands, rd and a write enable.
- Presents the result through a registered valid/ready output stage feeding the ALU/execute stage.

Parameters:
n, 32, datapath width of rs1_data/rs2_data/pc/A/B; n >= 32; immediates sign-extended to n.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard any held output (branch redirect)
in_valid  input  1  instruction/operands valid
in_ready  output  1  stage can accept this cycle
instr  input  32  RV32I instruction word
rs1_data  input  n  register file read port 1
rs2_data  input  n  register file read port 2
pc  input  n  instruction address
out_valid  output  1  decoded op valid
out_ready  input  1  ALU/execute stage accepts
AluOp  output  4  ALU operation code
A  output  n  ALU operand A
B  output  n  ALU operand B
rd  output  5  destination register
wen  output  1  register write enable

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0; AluOp=0, A=0, B=0, rd=0, wen=0. Reset mid-operation drops any held op.
- in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready && !flush. Decoded fields are registered; latency 1 cycle, so out_valid=1 on the next edge.
- Hold: while out_valid && !out_ready, all outputs stay stable and in_ready=0.
- Simultaneous drain and accept (out_valid, out_ready and in_valid all 1): the new op replaces the old one in the same edge; throughput is 1 op/cycle.
- Drain without a new input: out_valid clears on the next edge.
- flush=1: out_valid=0 on the next edge. Flush beats accept; the input offered that cycle is dropped.
- AluOp encoding (fixed, shared with the ALU):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 9 OR, 10 AND.
  - 8, 11-15 are never issued.
- OP (opcode 0110011): A=rs1_data, B=rs2_data.
  - funct3 000: funct7 0000000 gives ADD; funct7 0100000 gives SUB.
  - Other funct3 values map in order: 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (funct7 0000000) or SRA (funct7 0100000), 110 OR, 111 AND.
  - Any other funct7 is illegal.
- OP-IMM (0010011): A=rs1_data, B=sign-extended instr[31:20].
  - Same funct3 map; funct3 000 is always ADD.
  - Shifts: B = zero-extended instr[24:20].
  - funct3 101: instr[31:25]=0100000 gives SRA, 0000000 gives SRL, anything else is illegal.
  - funct3 001 requires instr[31:25]=0, otherwise illegal.
- LUI (0110111): AluOp=ADD, A=0, B = {instr[31:12], 12'b0} sign-extended to n.
- AUIPC (0010111): AluOp=ADD, A=pc, B as for LUI.
- rd = instr[11:7]. wen=1 for legal ops with rd != 0.
- All other opcodes and illegal encodings: AluOp=0, A=0, B=0, wen=0. They are still accepted and issued as a bubble op with out_valid=1.

Optional Feature:
- Macro: ALU_ILLEGAL_EN.
- Defined:
  - Adds an output port illegal (1 bit), registered alongside the other fields.
  - illegal=1 with out_valid for any illegal encoding; reset value 0.
  - illegal holds under backpressure like the other fields.
- Undefined: no port; illegal encodings silently become the bubble op.

Test Plan:
- ADD x3,x1,x2: instr=0x002081B3, rs1=5, rs2=7 -> next cycle out_valid=1, AluOp=0, A=5, B=7, rd=3, wen=1.
- SUB: instr=0x402081B3, rs1=5, rs2=7 -> AluOp=1, A=5, B=7.
- ADDI x5,x0,-1: instr=0xFFF00293, rs1=0 -> AluOp=0, A=0, B=0xFFFFFFFF, rd=5, wen=1.
- ORI x6,x6,0x0F0: instr=0x0F036313 -> AluOp=9, B=0x000000F0.
- LUI x1,0x12345: instr=0x123450B7 -> AluOp=0, A=0, B=0x12345000.
- Backpressure and flush: hold out_ready=0 for 3 cycles with in_valid=1.
  - Expect outputs stable and in_ready=0 for those 3 cycles.
  - Raising out_ready issues the next op on the following edge.
  - Asserting flush with out_ready=0 gives out_valid=0 on the next edge.
  - Asserting rst mid-hold gives all outputs 0.
- Illegal opcode: instr=0x0000007F -> wen=0, AluOp=0; illegal=1 when ALU_ILLEGAL_EN is defined.
